// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared state encoding and sizing helpers for the iterative BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    function automatic int nd_of(input int w);
        return (w + (w - 4) / 3) / 4 + 1;
    endfunction

    function automatic int nc_of(input int w, input int bpc);
        return (w + bpc - 1) / bpc;
    endfunction

endpackage

// File: rtl/bin2bcd_step.sv
// bin2bcd_step: one combinational add-3/shift slice over ND BCD digits with a serial carry-in bit.
module bin2bcd_step #(
    parameter int ND = 6
) (
    input  logic [4*ND-1:0] acc,
    input  logic            cin,
    output logic [4*ND-1:0] nacc
);
    localparam int DW = 4 * ND;
    logic [DW-1:0] adj;
    for (genvar d = 0; d < ND; d++) begin : g_dig
        assign adj[4*d+:4] = (acc[4*d+:4] > 4'd4) ? acc[4*d+:4] + 4'd3 : acc[4*d+:4];
    end
    assign nacc = (adj << 1) | DW'(cin);
endmodule

// File: rtl/bin2bcd_iter.sv
// bin2bcd_iter: iterative double-dabble binary-to-BCD converter, BPC bits per cycle, valid/ready on both sides.
// Define BIN2BCD_ITER_SIGNED_EN to treat in_bin as two's complement and report the sign on out_neg.
module bin2bcd_iter
    import bin2bcd_pkg::*;
#(
    parameter int W   = 18,
    parameter int BPC = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [W-1:0]                  in_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [4*nd_of(W)-1:0]         out_bcd,
    output logic                          out_neg
);
    localparam int ND = nd_of(W);
    localparam int NC = nc_of(W, BPC);
    localparam int WE = NC * BPC;
    localparam int CW = NC > 1 ? $clog2(NC) : 1;
    state_t state, nstate;
    logic [4*ND-1:0] acc;
    logic [WE-1:0] sr;
    logic [CW-1:0] cnt;
    logic [W-1:0] mag;
    logic [4*ND-1:0] chain [BPC+1];
    logic accept, last;
    assign chain[0] = acc;
    for (genvar i = 0; i < BPC; i++) begin : g_step
        bin2bcd_step #(.ND(ND)) u_step (.acc(chain[i]), .cin(sr[WE-1-i]), .nacc(chain[i+1]));
    end
`ifdef BIN2BCD_ITER_SIGNED_EN
    logic neg, neg_r;
    assign neg = in_bin[W-1];
    // -2^(W-1) negates to itself, which read unsigned is the correct magnitude
    assign mag = neg ? W'(-in_bin) : in_bin;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            neg_r   <= 1'b0;
            out_neg <= 1'b0;
        end else begin
            if (accept) neg_r <= neg;
            if (last) out_neg <= neg_r;
        end
`else
    assign mag = in_bin;
    assign out_neg = 1'b0;
`endif
    always_comb begin
        accept = state == IDLE && in_valid;
        last = state == CONV && cnt == '0;
        in_ready = state == IDLE;
        nstate = state;
        if (accept) nstate = CONV;
        if (last) nstate = DONE;
        if (state == DONE && out_valid && out_ready) nstate = IDLE;
    end
    // out_valid rises the cycle after DONE entry and falls on the accepting handshake edge
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            acc       <= '0;
            sr        <= '0;
            cnt       <= '0;
            out_bcd   <= '0;
        end else begin
            state     <= nstate;
            out_valid <= state == DONE && !(out_valid && out_ready);
            if (accept) begin
                acc <= '0;
                sr  <= WE'(mag);
                cnt <= CW'(NC - 1);
            end else if (state == CONV) begin
                acc <= chain[BPC];
                sr  <= sr << BPC;
                cnt <= cnt - 1'b1;
            end
            if (last) out_bcd <= chain[BPC];
        end
endmodule

// File: tb/tb_bin2bcd_iter.sv
// tb_bin2bcd_iter: directed checks of three converter instances (BPC = 1, 4, 3) at W = 18.
module tb_bin2bcd_iter;
    logic clk, rst;
    logic [2:0] in_valid, in_ready, out_valid, out_ready, out_neg;
    logic [2:0][17:0] in_bin;
    logic [2:0][23:0] out_bcd;
    int checks = 0;
    int errors = 0;

    bin2bcd_iter #(.W(18), .BPC(1)) u_b1 (.clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_bin(in_bin[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_bcd(out_bcd[0]), .out_neg(out_neg[0]));
    bin2bcd_iter #(.W(18), .BPC(4)) u_b4 (.clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_bin(in_bin[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_bcd(out_bcd[1]), .out_neg(out_neg[1]));
    bin2bcd_iter #(.W(18), .BPC(3)) u_b3 (.clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_bin(in_bin[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_bcd(out_bcd[2]), .out_neg(out_neg[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // accept one word, measure edges until out_valid, check result; rdy=1 also completes the handshake
    task automatic conv(input int i, input logic [17:0] v, input int lat, input logic [23:0] exp,
                        input logic eneg, input logic rdy);
        int n;
        @(negedge clk);
        in_bin[i] = v;
        in_valid[i] = 1'b1;
        out_ready[i] = rdy;
        chk("accept_in_ready", 32'(in_ready[i]), 1);
        @(posedge clk);
        #1 in_valid[i] = 1'b0;
        n = 0;
        chk("busy_in_ready", 32'(in_ready[i]), 0);
        while (!out_valid[i] && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        chk("latency", n, lat);
        chk("bcd", 32'(out_bcd[i]), 32'(exp));
        chk("neg", 32'(out_neg[i]), 32'(eneg));
        chk("done_in_ready", 32'(in_ready[i]), 0);
        if (rdy) begin
            @(posedge clk);
            #1;
            chk("release_valid", 32'(out_valid[i]), 0);
            chk("release_in_ready", 32'(in_ready[i]), 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = '0;
        out_ready = '0;
        in_bin = '0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'b111);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_neg", 32'(out_neg), 0);
        chk("rst_bcd0", 32'(out_bcd[0]), 0);
        chk("rst_bcd1", 32'(out_bcd[1]), 0);
        @(negedge clk) rst = 1'b0;

        conv(0, 18'd262143, 19, 24'h262143, 1'b0, 1'b1);
        conv(1, 18'd0, 6, 24'h000000, 1'b0, 1'b1);
        conv(1, 18'd99999, 6, 24'h099999, 1'b0, 1'b1);

        conv(1, 18'd4321, 6, 24'h004321, 1'b0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            in_valid[1] = 1'b1;
            in_bin[1] = 18'd999;
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid[1]), 1);
            chk("hold_bcd", 32'(out_bcd[1]), 32'h004321);
            chk("hold_in_ready", 32'(in_ready[1]), 0);
        end
        @(negedge clk);
        in_valid[1] = 1'b0;
        out_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 32'(out_valid[1]), 0);
        chk("bp_release_in_ready", 32'(in_ready[1]), 1);
        @(posedge clk);
        #1 chk("idle_bcd_held", 32'(out_bcd[1]), 32'h004321);

        conv(1, 18'd55, 6, 24'h000055, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_done_valid", 32'(out_valid[1]), 0);
        chk("rst_done_in_ready", 32'(in_ready[1]), 1);
        chk("rst_done_bcd", 32'(out_bcd[1]), 0);
        @(negedge clk) rst = 1'b0;

        @(negedge clk);
        in_bin[0] = 18'd12345;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_conv_in_ready", 32'(in_ready[0]), 1);
        chk("rst_conv_valid", 32'(out_valid[0]), 0);
        @(negedge clk) rst = 1'b0;
        repeat (25) @(posedge clk);
        #1 chk("rst_conv_no_result", 32'(out_valid[0]), 0);
        conv(0, 18'd777, 19, 24'h000777, 1'b0, 1'b1);

        conv(2, 18'd1000, 7, 24'h001000, 1'b0, 1'b1);

`ifdef BIN2BCD_ITER_SIGNED_EN
        conv(1, 18'h20000, 6, 24'h131072, 1'b1, 1'b1);
        conv(1, 18'h3FFFF, 6, 24'h000001, 1'b1, 1'b1);
        conv(1, 18'h1FFFF, 6, 24'h131071, 1'b0, 1'b1);
`else
        conv(1, 18'h20000, 6, 24'h131072, 1'b0, 1'b1);
        conv(1, 18'h1FFFF, 6, 24'h131071, 1'b0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
